// File: rtl/me_pkg.sv
`default_nettype none
// ============================================================================
// Module   : me_pkg
// Brief    : Shared types and constants for the SAD motion-search scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package me_pkg;

    localparam int c_pixels_in_batch = 16;
    localparam int c_bit_depth       = 8;
    localparam int c_block_pixels    = 64;
    localparam int c_search_rows     = 16;
    localparam int c_psad_bits       = 14;

    localparam int c_pix_aw  = $clog2(c_block_pixels);
    localparam int c_row_aw  = $clog2(c_search_rows);
    localparam int c_lane_aw = $clog2(c_pixels_in_batch);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        ACC  = 3'd2,
        CMP  = 3'd3,
        DONE = 3'd4
    } state_t;

    // Narrowest lane width that can hold a full-block SAD without wrapping.
    function automatic int psad_min_bits(input int bit_depth, input int block_pixels);
        return bit_depth + $clog2(block_pixels);
    endfunction

endpackage
`default_nettype wire

// File: rtl/me_min_tracker.sv
`default_nettype none
// ============================================================================
// Module   : me_min_tracker
// Brief    : Sequential compare-and-hold of the smallest SAD and its vector.
// Revision : 1.0 - initial release
// ============================================================================
module me_min_tracker #(
    parameter int PSAD_BITS = 14,
    parameter int ROW_W     = 4,
    parameter int COL_W     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 update_en,
    input  logic [PSAD_BITS-1:0] cand_sad,
    input  logic [ROW_W-1:0]     cand_row,
    input  logic [COL_W-1:0]     cand_col,
    output logic [PSAD_BITS-1:0] best_sad,
    output logic [ROW_W-1:0]     best_row,
    output logic [COL_W-1:0]     best_col
);

    // Strict less-than keeps the earliest candidate on ties.
    always_ff @(posedge clk) begin
        if (rst) begin
            best_sad <= '0;
            best_row <= '0;
            best_col <= '0;
        end else if (clear) begin
            best_sad <= '1;
            best_row <= '0;
            best_col <= '0;
        end else if (update_en && (cand_sad < best_sad)) begin
            best_sad <= cand_sad;
            best_row <= cand_row;
            best_col <= cand_col;
        end
    end

endmodule
`default_nettype wire

// File: rtl/me_sad_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : me_sad_scheduler
// Brief    : Full-search SAD sequencer: read addressing, PSAD accumulator and
//            minimum tracking around one external AD stage.
// Revision : 1.0 - initial release
// ============================================================================
module me_sad_scheduler
    import me_pkg::*;
#(
    parameter int PIXELS_IN_BATCH = c_pixels_in_batch,
    parameter int BIT_DEPTH       = c_bit_depth,
    parameter int BLOCK_PIXELS    = c_block_pixels,
    parameter int SEARCH_ROWS     = c_search_rows,
    parameter int PSAD_BITS       = c_psad_bits
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 rd_en,
    output logic [$clog2(BLOCK_PIXELS)-1:0]      cur_addr,
    output logic [$clog2(SEARCH_ROWS)-1:0]       ref_row,
    output logic [$clog2(BLOCK_PIXELS)-1:0]      ref_pix,
    output logic [PSAD_BITS*PIXELS_IN_BATCH-1:0] psad_to_ad,
    input  logic [PSAD_BITS*PIXELS_IN_BATCH-1:0] psad_from_ad,
    output logic [PSAD_BITS-1:0]                 best_sad,
    output logic [$clog2(SEARCH_ROWS)-1:0]       best_row,
    output logic [$clog2(PIXELS_IN_BATCH)-1:0]   best_col
);

    localparam int PIX_AW  = $clog2(BLOCK_PIXELS);
    localparam int ROW_AW  = $clog2(SEARCH_ROWS);
    localparam int LANE_AW = $clog2(PIXELS_IN_BATCH);

    localparam logic [PIX_AW-1:0]  C_K_LAST   = PIX_AW'(BLOCK_PIXELS - 1);
    localparam logic [LANE_AW-1:0] C_C_LAST   = LANE_AW'(PIXELS_IN_BATCH - 1);
    localparam logic [ROW_AW-1:0]  C_ROW_LAST = ROW_AW'(SEARCH_ROWS - 1);

    state_t                               r_state;
    state_t                               w_next;
    logic [PIX_AW-1:0]                    r_k;
    logic [LANE_AW-1:0]                   r_c;
    logic [ROW_AW-1:0]                    r_row;
    logic [PSAD_BITS*PIXELS_IN_BATCH-1:0] r_acc;
    logic [PIX_AW-1:0]                    w_k_inc;
    logic                                 w_clear;
    logic [PSAD_BITS-1:0]                 w_lane [PIXELS_IN_BATCH];

    if (PSAD_BITS < psad_min_bits(BIT_DEPTH, BLOCK_PIXELS)) begin : g_psad_width_check
        $error("PSAD_BITS is too narrow for BIT_DEPTH and BLOCK_PIXELS");
    end

    for (genvar g = 0; g < PIXELS_IN_BATCH; g++) begin : g_lane
        assign w_lane[g] = r_acc[g*PSAD_BITS +: PSAD_BITS];
    end

    assign w_k_inc    = r_k + PIX_AW'(1);
    assign w_clear    = (r_state == IDLE) && start;
    assign psad_to_ad = r_acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = LOAD;
            LOAD:    w_next = ACC;
            ACC:     if (r_k == C_K_LAST) w_next = CMP;
            CMP:     if (r_c == C_C_LAST) w_next = (r_row == C_ROW_LAST) ? DONE : LOAD;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Reads run one cycle ahead of the AD stage: LOAD fetches pixel 0, ACC k fetches k+1.
    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        rd_en    = 1'b0;
        cur_addr = '0;
        ref_pix  = '0;
        ref_row  = '0;
        case (r_state)
            LOAD: begin
                busy    = 1'b1;
                rd_en   = 1'b1;
                ref_row = r_row;
            end
            ACC: begin
                busy     = 1'b1;
                rd_en    = (r_k != C_K_LAST);
                cur_addr = w_k_inc;
                ref_pix  = w_k_inc;
                ref_row  = r_row;
            end
            CMP:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_k   <= '0;
            r_c   <= '0;
            r_row <= '0;
            r_acc <= '0;
        end else begin
            case (r_state)
                IDLE: if (start) r_row <= '0;
                LOAD: begin
                    r_acc <= '0;
                    r_k   <= '0;
                end
                ACC: begin
                    r_acc <= psad_from_ad;
                    r_k   <= w_k_inc;
                    r_c   <= '0;
                end
                CMP: begin
                    r_c <= r_c + LANE_AW'(1);
                    if (r_c == C_C_LAST) r_row <= r_row + ROW_AW'(1);
                end
                default: ;
            endcase
        end
    end

    me_min_tracker #(
        .PSAD_BITS (PSAD_BITS),
        .ROW_W     (ROW_AW),
        .COL_W     (LANE_AW)
    ) u_min_tracker (
        .clk       (clk),
        .rst       (rst),
        .clear     (w_clear),
        .update_en (r_state == CMP),
        .cand_sad  (w_lane[r_c]),
        .cand_row  (r_row),
        .cand_col  (r_c),
        .best_sad  (best_sad),
        .best_row  (best_row),
        .best_col  (best_col)
    );

endmodule
`default_nettype wire

// File: doc/me_sad_scheduler.md
Name: me_sad_scheduler

Overview:
- Sequences one AD stage (PIXELS_IN_BATCH parallel absolute-difference lanes) over a full-search motion-estimation window.
- Issues current/reference read addresses and owns the PSAD accumulator that the AD stage reads and writes back each cycle.
- Scans the finished SADs of each batch one per cycle and tracks the minimum SAD and its motion vector.
- Sits between the current-block/search-window buffers and the AD datapath; reports the best vector to the MV output stage.

Parameters:
PIXELS_IN_BATCH, 16, horizontal candidates evaluated in parallel (AD lanes)
BIT_DEPTH, 8, pixel width
BLOCK_PIXELS, 64, pixels per current block (8x8); power of two
SEARCH_ROWS, 16, vertical candidate offsets
PSAD_BITS, 14, per-lane SAD width; must be >= BIT_DEPTH+clog2(BLOCK_PIXELS) (elaboration check)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
start  in  1  begin a search; sampled only in IDLE
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse when the result is valid
rd_en  out  1  read strobe to both buffers; data returns 1 cycle later
cur_addr  out  clog2(BLOCK_PIXELS)  current-block pixel index
ref_row  out  clog2(SEARCH_ROWS)  vertical offset of the reference batch
ref_pix  out  clog2(BLOCK_PIXELS)  pixel index within the reference batch
psad_to_ad  out  PSAD_BITS*PIXELS_IN_BATCH  accumulator to AD psad_input
psad_from_ad  in  PSAD_BITS*PIXELS_IN_BATCH  AD psad_output (combinational path)
best_sad  out  PSAD_BITS  minimum SAD found
best_row  out  clog2(SEARCH_ROWS)  vertical index of the minimum
best_col  out  clog2(PIXELS_IN_BATCH)  lane index of the minimum

Behaviour:
- Reset: state IDLE; busy, done, rd_en = 0; all addresses = 0; accumulator = 0; best_sad = 0; best_row, best_col = 0.
- IDLE: start=1 -> LOAD, busy=1 next cycle. Search state init: best_sad = all ones, row = 0.
- LOAD (1 cycle):
  - clear accumulator;
  - rd_en=1, cur_addr=0, ref_pix=0, ref_row=row;
  - -> ACC, k=0.
- ACC (BLOCK_PIXELS cycles, k = 0..BLOCK_PIXELS-1):
  - buffer data for pixel k is present at the AD inputs;
  - accumulator <= psad_from_ad;
  - if k < BLOCK_PIXELS-1: rd_en=1, addresses = k+1; otherwise rd_en=0;
  - after k = BLOCK_PIXELS-1 -> CMP, c=0.
- CMP (PIXELS_IN_BATCH cycles, c = 0..PIXELS_IN_BATCH-1):
  - if lane c SAD < best_sad (strict): best_sad = lane c SAD, best_row = row, best_col = c;
  - ties keep the earlier candidate (lower row, then lower col);
  - after c = PIXELS_IN_BATCH-1: if row = SEARCH_ROWS-1 -> DONE, else row+1 -> LOAD.
- DONE (1 cycle): done=1, busy=0 -> IDLE. best_* held until the next start is accepted; they may update during a following search.
- Latency: done is high in cycle SEARCH_ROWS*(1+BLOCK_PIXELS+PIXELS_IN_BATCH)+1 after the start-sampling edge (1297 at defaults).
- Arithmetic:
  - unsigned throughout;
  - accumulator lanes never overflow, guaranteed by the PSAD_BITS check;
  - comparison is unsigned, full PSAD_BITS.
- start while busy or in DONE: ignored, no queuing.
- rst mid-operation: abort immediately to the reset values; no done pulse; the next start runs a clean search.
- psad_to_ad is the registered accumulator only; no combinational path from psad_from_ad to any output.

Decomposition:
- Shared package me_pkg holds:
  - state enum {IDLE, LOAD, ACC, CMP, DONE};
  - localparams for address widths (clog2 of BLOCK_PIXELS, SEARCH_ROWS, PIXELS_IN_BATCH);
  - PSAD_BITS minimum-width function.
- One natural sub-module: me_min_tracker (sequential compare-and-hold of best_sad/row/col, with clear and update enable).
- The AD stage is instantiated beside this block by the parent, not inside it.

Test Plan:
- Both buffers all zero, start -> done at cycle 1297; best_sad=0, best_row=0, best_col=0.
- Reference equals current only at row 5 lane 9; elsewhere every pixel differs by 1 -> best_sad=0, best_row=5, best_col=9.
- Current all 255, reference all 0 -> every SAD 16320, no wrap; best_sad=16320, best (0,0).
- Exact matches at (3,7) and (3,2) and (10,0) -> best (3,2), best_sad=0; tie ordering holds.
- start pulsed at cycles 10 and 600 during a search -> ignored, single done at 1297; rd_en low in CMP/IDLE/DONE.
- rst asserted in ACC at k=20 -> next cycle busy=0 and all outputs at reset values, no done; a following start completes correctly.
